// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// CSR indices, cause codes, mstatus fields and FSM states.
package trap_pkg;

   localparam int unsigned CSR_MSTATUS = 0;
   localparam int unsigned CSR_MISA    = 1;
   localparam int unsigned CSR_MIE     = 2;
   localparam int unsigned CSR_MTVEC   = 3;
   localparam int unsigned CSR_MEPC    = 4;
   localparam int unsigned CSR_MCAUSE  = 5;
   localparam int unsigned CSR_MTVAL   = 6;
   localparam int unsigned CSR_MIP     = 7;

   localparam logic [3:0] CODE_ILLEGAL = 4'd2;
   localparam logic [3:0] CODE_EBREAK  = 4'd3;
   localparam logic [3:0] CODE_ECALL   = 4'd11;
   localparam logic [3:0] CODE_MSI     = 4'd3;
   localparam logic [3:0] CODE_MTI     = 4'd7;
   localparam logic [3:0] CODE_MEI     = 4'd11;

   localparam int unsigned MST_MIE    = 3;
   localparam int unsigned MST_MPIE   = 7;
   localparam int unsigned MST_MPP_LO = 11;
   localparam int unsigned MST_MPP_HI = 12;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_W_MEPC  = 3'd1,
      S_W_MCAUS = 3'd2,
      S_W_MTVAL = 3'd3,
      S_W_MSTAT = 3'd4,
      S_T_REDIR = 3'd5,
      S_M_MSTAT = 3'd6,
      S_M_REDIR = 3'd7
   } trap_state_e;

   typedef struct packed {
      logic       valid;
      logic       is_irq;
      logic [3:0] code;
   } trap_cause_t;

   // Save MIE into MPIE, mask interrupts, record M-mode as previous
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      r[MST_MPIE] = s[MST_MIE];
      r[MST_MIE]  = 1'b0;
      r[MST_MPP_HI:MST_MPP_LO] = 2'b11;
      return r;
   endfunction

   // Restore MIE from MPIE and re-arm MPIE; MPP is left alone
   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      r[MST_MIE]  = s[MST_MPIE];
      r[MST_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trap_cause_arbiter.sv
// Fixed-priority trap cause selection.
// Interrupts beat exceptions; result gated by instr_valid.
module trap_cause_arbiter
   import trap_pkg::*;
(
   input  logic        i_instr_valid,
   input  logic        i_exc_illegal,
   input  logic        i_exc_ebreak,
   input  logic        i_exc_ecall,
   input  logic        i_ext_irq,
   input  logic        i_sw_irq,
   input  logic        i_timer_irq,
   input  logic        i_mien,
   input  logic        i_meien,
   input  logic        i_msien,
   input  logic        i_mtien,
   output trap_cause_t o_cause
);

   logic w_mei;
   logic w_msi;
   logic w_mti;
   logic w_irq;
   logic w_exc;

   assign w_mei = i_mien & i_meien & i_ext_irq;
   assign w_msi = i_mien & i_msien & i_sw_irq;
   assign w_mti = i_mien & i_mtien & i_timer_irq;
   assign w_irq = w_mei | w_msi | w_mti;
   assign w_exc = i_exc_illegal | i_exc_ebreak | i_exc_ecall;

   // Priority encode: MEI > MSI > MTI > illegal > ebreak > ecall
   always_comb begin
      o_cause = '0;
      if (i_instr_valid) begin
         if (w_irq) begin
            o_cause.valid  = 1'b1;
            o_cause.is_irq = 1'b1;
            if (w_mei)      o_cause.code = CODE_MEI;
            else if (w_msi) o_cause.code = CODE_MSI;
            else            o_cause.code = CODE_MTI;
         end else if (w_exc) begin
            o_cause.valid = 1'b1;
            if (i_exc_illegal)     o_cause.code = CODE_ILLEGAL;
            else if (i_exc_ebreak) o_cause.code = CODE_EBREAK;
            else                   o_cause.code = CODE_ECALL;
         end
      end
   end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap / mret sequencer driving the CSR write port.
// Saves trap state, updates mstatus and redirects the PC.
module trap_controller
   import trap_pkg::*;
#(
   parameter bit          VECTORED_EN = 1'b1,
   parameter int unsigned CSR_ADD_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   input  logic [31:0]          pc,
   input  logic                 exc_illegal,
   input  logic                 exc_ebreak,
   input  logic                 exc_ecall,
   input  logic [31:0]          exc_tval,
   input  logic                 mret,
   input  logic                 ext_irq,
   input  logic                 sw_irq,
   input  logic                 timer_irq,
   input  logic                 MIEN,
   input  logic                 MEIEN,
   input  logic                 MTIEN,
   input  logic                 MSIEN,
   input  logic [31:0]          csr_rd_data,
   output logic                 trap_csr_sel,
   output logic [CSR_ADD_W-1:0] trap_csr_add,
   output logic [31:0]          trap_csr_wr_data,
   output logic                 trap_csr_write,
   output logic                 take_trap,
   output logic                 stall,
   output logic                 redirect,
   output logic [31:0]          redirect_pc,
   output logic                 handling_mode
);

   localparam logic [CSR_ADD_W-1:0] A_MSTATUS = CSR_ADD_W'(CSR_MSTATUS);
   localparam logic [CSR_ADD_W-1:0] A_MTVEC   = CSR_ADD_W'(CSR_MTVEC);
   localparam logic [CSR_ADD_W-1:0] A_MEPC    = CSR_ADD_W'(CSR_MEPC);
   localparam logic [CSR_ADD_W-1:0] A_MCAUSE  = CSR_ADD_W'(CSR_MCAUSE);
   localparam logic [CSR_ADD_W-1:0] A_MTVAL   = CSR_ADD_W'(CSR_MTVAL);

   trap_state_e r_state;
   trap_state_e w_next;

   logic [31:0] r_epc;
   logic [31:0] r_cause;
   logic [31:0] r_tval;
   logic        r_handling;

   trap_cause_t w_cause;
   logic        w_idle;
   logic        w_take_trap;
   logic        w_take_mret;
   logic [31:0] w_base;
   logic        w_vec;

   trap_cause_arbiter u_arb (
      .i_instr_valid (instr_valid),
      .i_exc_illegal (exc_illegal),
      .i_exc_ebreak  (exc_ebreak),
      .i_exc_ecall   (exc_ecall),
      .i_ext_irq     (ext_irq),
      .i_sw_irq      (sw_irq),
      .i_timer_irq   (timer_irq),
      .i_mien        (MIEN),
      .i_meien       (MEIEN),
      .i_msien       (MSIEN),
      .i_mtien       (MTIEN),
      .o_cause       (w_cause)
   );

   assign w_idle      = (r_state == S_IDLE) & ~rst;
   assign w_take_trap = w_idle & w_cause.valid;
   assign w_take_mret = w_idle & instr_valid & mret & ~w_cause.valid;

   assign w_base = {csr_rd_data[31:2], 2'b00};
   assign w_vec  = VECTORED_EN & csr_rd_data[0] & r_cause[31];

   assign take_trap     = w_take_trap;
   assign handling_mode = r_handling & ~rst;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Capture trap context on accept; track handler activity
   always_ff @(posedge clk) begin
      if (rst) begin
         r_epc      <= '0;
         r_cause    <= '0;
         r_tval     <= '0;
         r_handling <= 1'b0;
      end else begin
         if (w_take_trap) begin
            r_epc   <= pc;
            r_cause <= {w_cause.is_irq, 27'b0, w_cause.code};
            r_tval  <= w_cause.is_irq ? 32'd0 : exc_tval;
         end
         if (r_state == S_T_REDIR)      r_handling <= 1'b1;
         else if (r_state == S_M_REDIR) r_handling <= 1'b0;
      end
   end

   // Next-state sequencing
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_take_trap)      w_next = S_W_MEPC;
            else if (w_take_mret) w_next = S_M_MSTAT;
         end
         S_W_MEPC:  w_next = S_W_MCAUS;
         S_W_MCAUS: w_next = S_W_MTVAL;
         S_W_MTVAL: w_next = S_W_MSTAT;
         S_W_MSTAT: w_next = S_T_REDIR;
         S_T_REDIR: w_next = S_IDLE;
         S_M_MSTAT: w_next = S_M_REDIR;
         S_M_REDIR: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // CSR port, stall and redirect per state; all quiet during reset
   always_comb begin
      trap_csr_sel     = 1'b0;
      trap_csr_add     = '0;
      trap_csr_wr_data = '0;
      trap_csr_write   = 1'b0;
      stall            = 1'b0;
      redirect         = 1'b0;
      redirect_pc      = '0;
      if (!rst) begin
         unique case (r_state)
            S_IDLE: begin
               stall = w_take_trap | w_take_mret;
            end
            S_W_MEPC: begin
               trap_csr_sel     = 1'b1;
               trap_csr_write   = 1'b1;
               stall            = 1'b1;
               trap_csr_add     = A_MEPC;
               trap_csr_wr_data = r_epc & 32'hFFFF_FFFC;
            end
            S_W_MCAUS: begin
               trap_csr_sel     = 1'b1;
               trap_csr_write   = 1'b1;
               stall            = 1'b1;
               trap_csr_add     = A_MCAUSE;
               trap_csr_wr_data = r_cause;
            end
            S_W_MTVAL: begin
               trap_csr_sel     = 1'b1;
               trap_csr_write   = 1'b1;
               stall            = 1'b1;
               trap_csr_add     = A_MTVAL;
               trap_csr_wr_data = r_tval;
            end
            S_W_MSTAT: begin
               trap_csr_sel     = 1'b1;
               trap_csr_write   = 1'b1;
               stall            = 1'b1;
               trap_csr_add     = A_MSTATUS;
               trap_csr_wr_data = mstatus_on_trap(csr_rd_data);
            end
            S_T_REDIR: begin
               trap_csr_sel = 1'b1;
               stall        = 1'b1;
               redirect     = 1'b1;
               trap_csr_add = A_MTVEC;
               redirect_pc  = w_vec
                  ? w_base + {26'b0, r_cause[3:0], 2'b00}
                  : w_base;
            end
            S_M_MSTAT: begin
               trap_csr_sel     = 1'b1;
               trap_csr_write   = 1'b1;
               stall            = 1'b1;
               trap_csr_add     = A_MSTATUS;
               trap_csr_wr_data = mstatus_on_mret(csr_rd_data);
            end
            S_M_REDIR: begin
               trap_csr_sel = 1'b1;
               stall        = 1'b1;
               redirect     = 1'b1;
               trap_csr_add = A_MEPC;
               redirect_pc  = csr_rd_data;
            end
            default: begin
               stall = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller with a CSR file model.
// Directed scenarios followed by randomized traffic.
module tb_trap_controller;
   import trap_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] pc = '0;
   logic        exc_illegal = 1'b0;
   logic        exc_ebreak = 1'b0;
   logic        exc_ecall = 1'b0;
   logic [31:0] exc_tval = '0;
   logic        mret = 1'b0;
   logic        ext_irq = 1'b0;
   logic        sw_irq = 1'b0;
   logic        timer_irq = 1'b0;
   logic        MIEN, MEIEN, MTIEN, MSIEN;
   logic [31:0] csr_rd_data;
   logic        trap_csr_sel;
   logic [3:0]  trap_csr_add;
   logic [31:0] trap_csr_wr_data;
   logic        trap_csr_write;
   logic        take_trap;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        handling_mode;

   logic [31:0] csr  [16];
   logic [31:0] mcsr [16];

   typedef struct {
      logic        wr;
      logic [3:0]  add;
      logic [31:0] data;
      logic        rd;
      logic [31:0] rpc;
      logic        hm;
   } rec_t;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] val;
   } set_t;

   rec_t q[$];
   set_t pq[$];
   logic hm = 1'b0;

   logic        pw = 1'b0;
   logic [3:0]  pa = '0;
   logic [31:0] pd = '0;

   logic        s_rst, s_iv, s_ill, s_ebk, s_ecl, s_mret;
   logic        s_ext, s_sw, s_tim;
   logic [31:0] s_pc, s_tval;

   int n_chk = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int stall_cnt = 0;
   int trap_cnt = 0;
   logic [31:0] last_rpc = '0;

   always #5 clk = ~clk;

   assign csr_rd_data = csr[trap_csr_add];
   assign MIEN  = csr[0][3];
   assign MEIEN = csr[2][11];
   assign MSIEN = csr[2][3];
   assign MTIEN = csr[2][7];

   trap_controller #(.VECTORED_EN(1'b1), .CSR_ADD_W(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .instr_valid      (instr_valid),
      .pc               (pc),
      .exc_illegal      (exc_illegal),
      .exc_ebreak       (exc_ebreak),
      .exc_ecall        (exc_ecall),
      .exc_tval         (exc_tval),
      .mret             (mret),
      .ext_irq          (ext_irq),
      .sw_irq           (sw_irq),
      .timer_irq        (timer_irq),
      .MIEN             (MIEN),
      .MEIEN            (MEIEN),
      .MTIEN            (MTIEN),
      .MSIEN            (MSIEN),
      .csr_rd_data      (csr_rd_data),
      .trap_csr_sel     (trap_csr_sel),
      .trap_csr_add     (trap_csr_add),
      .trap_csr_wr_data (trap_csr_wr_data),
      .trap_csr_write   (trap_csr_write),
      .take_trap        (take_trap),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .handling_mode    (handling_mode)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr();
      s_rst = 0; s_iv = 0; s_ill = 0; s_ebk = 0; s_ecl = 0;
      s_mret = 0; s_ext = 0; s_sw = 0; s_tim = 0;
      s_pc = '0; s_tval = '0;
   endtask

   task automatic set_csr(input logic [3:0] idx, input logic [31:0] val);
      set_t e;
      e.idx = idx;
      e.val = val;
      pq.push_back(e);
   endtask

   // Reference: accept decision and the full expected sequence
   task automatic model_accept(output logic acc_t, output logic acc_m);
      logic        e, s, t, irq, exc;
      logic [3:0]  code;
      logic [31:0] tv, ms, base, tgt, cause;
      e   = s_ext & mcsr[2][11];
      s   = s_sw  & mcsr[2][3];
      t   = s_tim & mcsr[2][7];
      irq = s_iv & mcsr[0][3] & (e | s | t);
      exc = s_iv & (s_ill | s_ebk | s_ecl);
      acc_t = irq | exc;
      acc_m = s_iv & s_mret & ~acc_t;
      code = 4'd0;
      tv = 32'd0;
      if (irq) begin
         code = e ? 4'd11 : (s ? 4'd3 : 4'd7);
      end else if (exc) begin
         code = s_ill ? 4'd2 : (s_ebk ? 4'd3 : 4'd11);
         tv = s_tval;
      end
      if (acc_t) begin
         cause = {irq, 27'b0, code};
         ms = mcsr[0];
         ms[7] = ms[3];
         ms[3] = 1'b0;
         ms[12:11] = 2'b11;
         base = mcsr[3] & 32'hFFFF_FFFC;
         tgt = (mcsr[3][0] && irq) ? base + 32'(code) * 4 : base;
         q.push_back('{1'b1, 4'd4, s_pc & 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0});
         q.push_back('{1'b1, 4'd5, cause, 1'b0, 32'd0, 1'b0});
         q.push_back('{1'b1, 4'd6, tv, 1'b0, 32'd0, 1'b0});
         q.push_back('{1'b1, 4'd0, ms, 1'b0, 32'd0, 1'b0});
         q.push_back('{1'b0, 4'd3, 32'd0, 1'b1, tgt, 1'b1});
      end else if (acc_m) begin
         ms = mcsr[0];
         ms[3] = ms[7];
         ms[7] = 1'b1;
         q.push_back('{1'b1, 4'd0, ms, 1'b0, 32'd0, 1'b0});
         q.push_back('{1'b0, 4'd4, 32'd0, 1'b1, mcsr[4], 1'b0});
      end
   endtask

   task automatic step();
      rec_t r;
      logic acc_t, acc_m;
      @(posedge clk);
      #1;
      if (pw) csr[pa] = pd;
      pw = 1'b0;
      foreach (pq[i]) begin
         csr[pq[i].idx]  = pq[i].val;
         mcsr[pq[i].idx] = pq[i].val;
      end
      pq.delete();
      rst = s_rst; instr_valid = s_iv; pc = s_pc;
      exc_illegal = s_ill; exc_ebreak = s_ebk; exc_ecall = s_ecl;
      exc_tval = s_tval; mret = s_mret;
      ext_irq = s_ext; sw_irq = s_sw; timer_irq = s_tim;
      #4;
      if (trap_csr_write) wr_cnt++;
      if (stall) stall_cnt++;
      if (take_trap) trap_cnt++;
      if (redirect) last_rpc = redirect_pc;
      if (s_rst) begin
         check("rst_stall", 32'(stall), 32'd0);
         check("rst_take", 32'(take_trap), 32'd0);
         check("rst_wr", 32'(trap_csr_write), 32'd0);
         check("rst_sel", 32'(trap_csr_sel), 32'd0);
         check("rst_redir", 32'(redirect), 32'd0);
         check("rst_hm", 32'(handling_mode), 32'd0);
         q.delete();
         hm = 1'b0;
      end else begin
         check("hm", 32'(handling_mode), 32'(hm));
         if (q.size() != 0) begin
            r = q.pop_front();
            check("seq_stall", 32'(stall), 32'd1);
            check("seq_take", 32'(take_trap), 32'd0);
            check("seq_sel", 32'(trap_csr_sel), 32'd1);
            check("seq_add", 32'(trap_csr_add), 32'(r.add));
            check("seq_wr", 32'(trap_csr_write), 32'(r.wr));
            check("seq_redir", 32'(redirect), 32'(r.rd));
            if (r.wr) begin
               check("seq_data", trap_csr_wr_data, r.data);
               mcsr[r.add] = r.data;
            end
            if (r.rd) begin
               check("seq_rpc", redirect_pc, r.rpc);
               hm = r.hm;
            end
         end else begin
            model_accept(acc_t, acc_m);
            check("idle_take", 32'(take_trap), 32'(acc_t));
            check("idle_stall", 32'(stall), 32'(acc_t | acc_m));
            check("idle_sel", 32'(trap_csr_sel), 32'd0);
            check("idle_wr", 32'(trap_csr_write), 32'd0);
            check("idle_redir", 32'(redirect), 32'd0);
         end
      end
      if (trap_csr_write) begin
         pw = 1'b1;
         pa = trap_csr_add;
         pd = trap_csr_wr_data;
      end
   endtask

   initial begin
      logic [3:0] idx;
      for (int i = 0; i < 16; i++) begin
         csr[i] = '0;
         mcsr[i] = '0;
      end
      clr();
      s_rst = 1'b1;
      repeat (3) step();
      clr();

      // External interrupt, vectored mtvec
      set_csr(4'd0, 32'h0000_1808);
      set_csr(4'd2, 32'h0000_0800);
      set_csr(4'd3, 32'h0000_0101);
      s_iv = 1; s_pc = 32'h40; s_ext = 1;
      stall_cnt = 0;
      step();
      clr();
      repeat (6) step();
      check("irq_mepc", csr[4], 32'h0000_0040);
      check("irq_mcause", csr[5], 32'h8000_000B);
      check("irq_mtval", csr[6], 32'h0);
      check("irq_mstatus", csr[0], 32'h0000_1880);
      check("irq_rpc", last_rpc, 32'h0000_012C);
      check("irq_stall_cycles", 32'(stall_cnt), 32'd6);
      check("irq_hm", 32'(handling_mode), 32'd1);

      // Illegal instruction: exceptions are never vectored
      s_iv = 1; s_pc = 32'h80; s_ill = 1; s_tval = 32'hFFFF_FFFF;
      step();
      clr();
      repeat (6) step();
      check("ill_mcause", csr[5], 32'h0000_0002);
      check("ill_mtval", csr[6], 32'hFFFF_FFFF);
      check("ill_rpc", last_rpc, 32'h0000_0100);

      // mret from the handler
      set_csr(4'd0, 32'h0000_1880);
      set_csr(4'd4, 32'h0000_0044);
      s_iv = 1; s_mret = 1;
      step();
      check("mret_hm_before", 32'(handling_mode), 32'd1);
      clr();
      repeat (3) step();
      check("mret_mstatus", csr[0], 32'h0000_1888);
      check("mret_rpc", last_rpc, 32'h0000_0044);
      check("mret_hm_after", 32'(handling_mode), 32'd0);

      // Priority: MEI over MSI over ecall
      set_csr(4'd0, 32'h0000_1808);
      set_csr(4'd2, 32'h0000_0888);
      set_csr(4'd3, 32'h0000_0000);
      s_iv = 1; s_pc = 32'h100; s_ext = 1; s_sw = 1; s_ecl = 1;
      step();
      clr();
      repeat (6) step();
      check("pri_mei", csr[5], 32'h8000_000B);
      set_csr(4'd0, 32'h0000_1808);
      set_csr(4'd2, 32'h0000_0088);
      s_iv = 1; s_pc = 32'h104; s_ext = 1; s_sw = 1; s_ecl = 1;
      step();
      clr();
      repeat (6) step();
      check("pri_msi", csr[5], 32'h8000_0003);
      set_csr(4'd0, 32'h0000_0000);
      set_csr(4'd2, 32'h0000_0888);
      s_iv = 1; s_pc = 32'h108; s_ext = 1; s_sw = 1; s_ecl = 1;
      step();
      clr();
      repeat (6) step();
      check("pri_ecall", csr[5], 32'h0000_000B);

      // Timer raised mid-sequence is ignored and masked afterwards
      set_csr(4'd0, 32'h0000_1808);
      set_csr(4'd2, 32'h0000_0080);
      trap_cnt = 0;
      s_iv = 1; s_pc = 32'h200; s_ecl = 1;
      step();
      clr();
      step();
      s_iv = 1; s_tim = 1; s_pc = 32'h204;
      repeat (7) step();
      clr();
      check("tim_traps", 32'(trap_cnt), 32'd1);
      check("tim_mcause", csr[5], 32'h0000_000B);

      // Reset in the middle of a trap sequence
      set_csr(4'd5, 32'hDEAD_BEEF);
      set_csr(4'd4, 32'h0);
      s_iv = 1; s_pc = 32'h300; s_ecl = 1;
      step();
      clr();
      step();
      s_rst = 1;
      step();
      clr();
      wr_cnt = 0;
      stall_cnt = 0;
      repeat (4) step();
      check("rst_mid_wr", 32'(wr_cnt), 32'd0);
      check("rst_mid_stall", 32'(stall_cnt), 32'd0);
      check("rst_mid_mepc", csr[4], 32'h0000_0300);
      check("rst_mid_mcause", csr[5], 32'hDEAD_BEEF);
      check("rst_mid_hm", 32'(handling_mode), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         clr();
         s_rst  = ($urandom_range(0, 99) < 2);
         s_iv   = ($urandom_range(0, 9) < 6);
         s_pc   = $urandom;
         s_ill  = ($urandom_range(0, 99) < 12);
         s_ebk  = ($urandom_range(0, 99) < 12);
         s_ecl  = ($urandom_range(0, 99) < 12);
         s_tval = $urandom;
         s_mret = ($urandom_range(0, 9) < 2);
         s_ext  = ($urandom_range(0, 3) == 0);
         s_sw   = ($urandom_range(0, 3) == 0);
         s_tim  = ($urandom_range(0, 3) == 0);
         if (q.size() == 0 && $urandom_range(0, 9) < 2) begin
            case ($urandom_range(0, 3))
               0: idx = 4'd0;
               1: idx = 4'd2;
               2: idx = 4'd3;
               default: idx = 4'd4;
            endcase
            set_csr(idx, $urandom);
         end
         step();
      end
      clr();
      repeat (8) step();
      for (int i = 0; i < 8; i++) check("csr_final", csr[i], mcsr[i]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
